hood_mode_ctrl: RTL and testbench

Parametrised fan-mode controller for the kitchen hood. It decodes the power, menu, level, self-clean and hurricane-enable inputs into a registered operating mode, a one-hot LED vector, and a live seconds countdown for timed modes. It sits between the button-conditioning logic and the fan/display drivers. It generalises the fixed three-speed controller to NUM_LEVELS speeds and adds real timed exits with parametrised durations.

---
 rtl/hood_mode_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hood_mode_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_mode_ctrl.sv
// Kitchen-hood fan mode controller: OFF / STANDBY / LEVEL 1..NUM_LEVELS / CLEAN, timed hurricane and clean.
// Optional `HOOD_HURRICANE_LOCK_EN: hurricane re-entry is refused until the block passes through STANDBY.

module hood_mode_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NUM_LEVELS  = 3,
  parameter int HURRICANE_S = 60,
  parameter int CLEAN_S     = 180,
  localparam int MW    = $clog2(NUM_LEVELS + 3),
  localparam int MAX_S = (HURRICANE_S > CLEAN_S) ? HURRICANE_S : CLEAN_S,
  localparam int TW    = $clog2(MAX_S + 1),
  localparam int LW    = NUM_LEVELS + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_on,
  input  logic                  menu_btn,
  input  logic [NUM_LEVELS-1:0] level_btn,
  input  logic                  clean_btn,
  input  logic                  hurricane_en,
  output logic [MW-1:0]         mode_state,
  output logic [LW-1:0]         led,
  output logic                  menu_armed,
  output logic [TW-1:0]         remaining_s
);

  localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [MW-1:0] TOP     = MW'(NUM_LEVELS);
  localparam logic [MW-1:0] M_CLEAN = MW'(NUM_LEVELS + 1);
  localparam logic [MW-1:0] M_OFF   = MW'(NUM_LEVELS + 2);

  typedef enum logic [1:0] {ST_OFF, ST_STANDBY, ST_LEVEL, ST_CLEAN} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   lvl_q, lvl_d;
  logic            armed_q, armed_d;
  logic            menu_prev_q;
  logic [TW-1:0]   rem_q, rem_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [LW-1:0]   led_q, led_d;

  logic                  menu_edge, top_ok;
  logic [NUM_LEVELS-1:0] allow_mask, own_mask;
  logic [MW-1:0]         sb_pick, lv_pick;
  logic                  in_hur, in_timed, tick, expire;
  logic                  hur_d, timed_d;

  // Level number (1-based) of the lowest set request bit, 0 when none.
  function automatic logic [MW-1:0] lowest_level(input logic [NUM_LEVELS-1:0] req);
    logic [MW-1:0] lvl;
    lvl = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--)
      if (req[i]) lvl = MW'(i + 1);
    return lvl;
  endfunction

  assign menu_edge = menu_btn & ~menu_prev_q;

  always_comb begin
    allow_mask = '1;
    allow_mask[NUM_LEVELS-1] = top_ok;
    own_mask = '0;
    for (int i = 0; i < NUM_LEVELS; i++)
      own_mask[i] = (lvl_q == MW'(i + 1));
  end

  assign sb_pick  = lowest_level(level_btn & allow_mask);
  assign lv_pick  = lowest_level(level_btn & allow_mask & ~own_mask);

  assign in_hur   = (state_q == ST_LEVEL) && (lvl_q == TOP);
  assign in_timed = in_hur || (state_q == ST_CLEAN);
  assign tick     = in_timed && (pre_q == PRE_MAX);
  assign expire   = tick && (rem_q == TW'(1));

  assign hur_d    = (state_d == ST_LEVEL) && (lvl_d == TOP);
  assign timed_d  = hur_d || (state_d == ST_CLEAN);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    armed_d = armed_q;
    rem_d   = rem_q;
    pre_d   = '0;
    if (in_timed) pre_d = tick ? '0 : pre_q + PW'(1);
    if (tick)     rem_d = rem_q - TW'(1);

    if (!power_on) begin
      state_d = ST_OFF;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_STANDBY;
        ST_STANDBY: begin
          if (menu_edge) armed_d = ~armed_q;
          // Acceptance decisions use the registered arm bit, not this cycle's toggle.
          if (armed_q) begin
            if (sb_pick != '0) begin
              state_d = ST_LEVEL;
              lvl_d   = sb_pick;
              armed_d = 1'b0;
            end else if (clean_btn) begin
              state_d = ST_CLEAN;
              armed_d = 1'b0;
            end
          end
        end
        ST_LEVEL: begin
          if (lvl_q == TOP) begin
            if (expire || menu_edge || !hurricane_en) lvl_d = TOP - MW'(1);
          end else if (menu_edge) begin
            state_d = ST_STANDBY;
          end else if (lv_pick != '0) begin
            lvl_d = lv_pick;
          end
        end
        ST_CLEAN: if (expire) state_d = ST_STANDBY;
        default:  state_d = ST_OFF;
      endcase
    end

    // Countdown only lives inside a timed mode; each entry restarts it from full.
    if (!timed_d) begin
      rem_d = '0;
      pre_d = '0;
    end else if (hur_d && !in_hur) begin
      rem_d = TW'(HURRICANE_S);
      pre_d = '0;
    end else if ((state_d == ST_CLEAN) && (state_q != ST_CLEAN)) begin
      rem_d = TW'(CLEAN_S);
      pre_d = '0;
    end
  end

  always_comb begin
    mode_d = M_OFF;
    led_d  = '0;
    case (state_d)
      ST_STANDBY: begin mode_d = '0;      led_d[0]    = 1'b1; end
      ST_LEVEL:   begin mode_d = lvl_d;   led_d       = LW'(1) << lvl_d; end
      ST_CLEAN:   begin mode_d = M_CLEAN; led_d[LW-1] = 1'b1; end
      default: ;
    endcase
  end

`ifdef HOOD_HURRICANE_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (in_hur && !hur_d) lock_d = 1'b1;
    if ((state_d == ST_OFF) || (state_d == ST_STANDBY)) lock_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end

  assign top_ok = hurricane_en & ~lock_q;
`else
  assign top_ok = hurricane_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      lvl_q       <= '0;
      armed_q     <= 1'b0;
      menu_prev_q <= 1'b0;
      rem_q       <= '0;
      pre_q       <= '0;
      mode_q      <= M_OFF;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      armed_q     <= armed_d;
      menu_prev_q <= menu_btn;
      rem_q       <= rem_d;
      pre_q       <= pre_d;
      mode_q      <= mode_d;
      led_q       <= led_d;
    end
  end

  assign mode_state  = mode_q;
  assign led         = led_q;
  assign menu_armed  = armed_q;
  assign remaining_s = rem_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Randomized + directed bench for hood_mode_ctrl against a mode/elapsed-cycles reference model.
// Define HOOD_HURRICANE_LOCK_EN for both bench and RTL to exercise the lock build.

module tb_hood_mode_ctrl;

  localparam int CLK = 10;
  localparam int NL  = 3;
  localparam int HS  = 3;
  localparam int CS  = 5;
  localparam int MW  = 3;
  localparam int LW  = NL + 2;
  localparam int TW  = 3;
  localparam int EW  = MW + LW + 1 + TW;
  localparam int OFF = NL + 2;
`ifdef HOOD_HURRICANE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk, rst, power_on, menu_btn, clean_btn, hurricane_en;
  logic [NL-1:0] level_btn;
  logic [MW-1:0] mode_state;
  logic [LW-1:0] led;
  logic          menu_armed;
  logic [TW-1:0] remaining_s;

  int checks = 0;
  int fails  = 0;

  hood_mode_ctrl #(.CLK_HZ(CLK), .NUM_LEVELS(NL), .HURRICANE_S(HS), .CLEAN_S(CS)) dut (
    .clk(clk), .rst(rst), .power_on(power_on), .menu_btn(menu_btn),
    .level_btn(level_btn), .clean_btn(clean_btn), .hurricane_en(hurricane_en),
    .mode_state(mode_state), .led(led), .menu_armed(menu_armed), .remaining_s(remaining_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode number, arm bit, cycles elapsed since entering a timed mode.
  typedef struct {
    int mode;
    bit armed;
    int el;
    bit lock;
    bit prev;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, bit r, bit p, bit mb, bit [NL-1:0] lb,
                                         bit cb, bit he);
    mstate_t n = s;
    bit e;
    int pick;
    e = mb && !s.prev;
    n.prev = mb;
    if (r) begin
      n.mode = OFF; n.armed = 0; n.el = 0; n.lock = 0; n.prev = 0;
      return n;
    end
    if (!p) begin
      n.mode = OFF; n.armed = 0; n.el = 0; n.lock = 0;
      return n;
    end
    pick = 0;
    for (int i = NL - 1; i >= 0; i--)
      if (lb[i] && (i < NL - 1 || (he && !s.lock)) && (i + 1 != s.mode)) pick = i + 1;
    if (s.mode == OFF) begin
      n.mode = 0;
    end else if (s.mode == 0) begin
      if (s.armed && pick != 0) begin
        n.mode = pick; n.armed = 0; n.el = 0;
      end else if (s.armed && cb) begin
        n.mode = NL + 1; n.armed = 0; n.el = 0;
      end else if (e) begin
        n.armed = !s.armed;
      end
    end else if (s.mode < NL) begin
      if (e) n.mode = 0;
      else if (pick != 0) begin n.mode = pick; n.el = 0; end
    end else if (s.mode == NL) begin
      if (s.el + 1 == HS * CLK || e || !he) begin
        n.mode = NL - 1; n.el = 0; n.lock = LOCK;
      end else n.el = s.el + 1;
    end else begin
      if (s.el + 1 == CS * CLK) begin n.mode = 0; n.el = 0; end
      else n.el = s.el + 1;
    end
    if (n.mode == 0) n.lock = 0;
    return n;
  endfunction

  function automatic logic [EW-1:0] exp_vec(mstate_t s);
    logic [LW-1:0] l;
    int r;
    l = '0;
    r = 0;
    if (s.mode != OFF) l[s.mode] = 1'b1;
    if (s.mode == NL)          r = HS - s.el / CLK;
    else if (s.mode == NL + 1) r = CS - s.el / CLK;
    return {MW'(s.mode), l, s.armed, TW'(r)};
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst, power_on, menu_btn, level_btn, clean_btn, hurricane_en);

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic menu_pulse();
    menu_btn = 1'b1; cyc();
    menu_btn = 1'b0; cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; power_on = 1'b1;
    cyc(); cyc();
    checks++;
    if (mode_state !== MW'(OFF) || led !== '0 || menu_armed !== 1'b0 || remaining_s !== '0) begin
      fails++; $display("FAIL reset_vals got mode=%0d led=%b armed=%b rem=%0d want mode=5 led=0 armed=0 rem=0",
                        mode_state, led, menu_armed, remaining_s);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (mode_state !== 3'd0 || led !== 5'b00001) begin
      fails++; $display("FAIL reset_release got mode=%0d led=%b want mode=0 led=00001", mode_state, led);
    end
    checks++;
    if ({mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
      fails++; $display("FAIL reset_model got=%b want=%b", {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
    end
  endtask

  task automatic test_levels();
    menu_pulse();
    checks++;
    if (menu_armed !== 1'b1) begin
      fails++; $display("FAIL arm got armed=%b want 1", menu_armed);
    end
    level_btn = 3'b001; cyc(); level_btn = '0;
    checks++;
    if (mode_state !== 3'd1 || led !== 5'b00010 || menu_armed !== 1'b0) begin
      fails++; $display("FAIL level1 got mode=%0d led=%b armed=%b want mode=1 led=00010 armed=0",
                        mode_state, led, menu_armed);
    end
    level_btn = 3'b010; cyc(); level_btn = '0;
    checks++;
    if (mode_state !== 3'd2 || led !== 5'b00100) begin
      fails++; $display("FAIL level2 got mode=%0d led=%b want mode=2 led=00100", mode_state, led);
    end
    // menu edge beats a level request in the same cycle
    menu_btn = 1'b1; level_btn = 3'b001; cyc(); menu_btn = 1'b0; level_btn = '0;
    checks++;
    if (mode_state !== 3'd0 || led !== 5'b00001 || menu_armed !== 1'b0) begin
      fails++; $display("FAIL menu_to_standby got mode=%0d led=%b armed=%b want mode=0 led=00001 armed=0",
                        mode_state, led, menu_armed);
    end
    cyc();
    checks++;
    if ({mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
      fails++; $display("FAIL levels_model got=%b want=%b", {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
    end
  endtask

  task automatic test_hurricane();
    hurricane_en = 1'b1;
    menu_pulse();
    level_btn = 3'b100; cyc(); level_btn = '0;
    checks++;
    if (mode_state !== 3'd3 || remaining_s !== 3'd3 || led !== 5'b01000) begin
      fails++; $display("FAIL hur_entry got mode=%0d rem=%0d led=%b want mode=3 rem=3 led=01000",
                        mode_state, remaining_s, led);
    end
    for (int i = 1; i <= HS * CLK; i++) begin
      cyc();
      checks++;
      if ({mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
        fails++; $display("FAIL hur_model cyc=%0d got=%b want=%b", i,
                          {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
      end
      if (i == CLK - 1 || i == CLK) begin
        checks++;
        if (remaining_s !== ((i == CLK) ? 3'd2 : 3'd3)) begin
          fails++; $display("FAIL hur_tick cyc=%0d got rem=%0d want %0d", i, remaining_s, (i == CLK) ? 2 : 3);
        end
      end
      if (i == HS * CLK - 1) begin
        checks++;
        if (mode_state !== 3'd3 || remaining_s !== 3'd1) begin
          fails++; $display("FAIL hur_before_exp got mode=%0d rem=%0d want mode=3 rem=1", mode_state, remaining_s);
        end
      end
    end
    checks++;
    if (mode_state !== 3'd2 || remaining_s !== 3'd0 || led !== 5'b00100) begin
      fails++; $display("FAIL hur_expiry got mode=%0d rem=%0d led=%b want mode=2 rem=0 led=00100",
                        mode_state, remaining_s, led);
    end
    menu_pulse();
  endtask

  task automatic test_hurricane_gated();
    menu_pulse();
    hurricane_en = 1'b0;
    level_btn = 3'b100; cyc(); level_btn = '0;
    checks++;
    if (mode_state !== 3'd0 || menu_armed !== 1'b1) begin
      fails++; $display("FAIL hur_gated got mode=%0d armed=%b want mode=0 armed=1", mode_state, menu_armed);
    end
    hurricane_en = 1'b1;
    menu_pulse();
    checks++;
    if (menu_armed !== 1'b0 || {mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
      fails++; $display("FAIL disarm got=%b want=%b", {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
    end
  endtask

  task automatic test_clean();
    menu_pulse();
    clean_btn = 1'b1; cyc(); clean_btn = 1'b0;
    checks++;
    if (mode_state !== 3'd4 || led !== 5'b10000 || remaining_s !== 3'd5) begin
      fails++; $display("FAIL clean_entry got mode=%0d led=%b rem=%0d want mode=4 led=10000 rem=5",
                        mode_state, led, remaining_s);
    end
    for (int i = 1; i <= CS * CLK; i++) begin
      menu_btn = (i == 20);
      level_btn = (i == 30) ? 3'b001 : 3'b000;
      cyc();
      checks++;
      if ({mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
        fails++; $display("FAIL clean_model cyc=%0d got=%b want=%b", i,
                          {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
      end
      if (i == CS * CLK - 1) begin
        checks++;
        if (mode_state !== 3'd4 || remaining_s !== 3'd1) begin
          fails++; $display("FAIL clean_before_exp got mode=%0d rem=%0d want mode=4 rem=1", mode_state, remaining_s);
        end
      end
    end
    menu_btn = 1'b0; level_btn = '0;
    checks++;
    if (mode_state !== 3'd0 || led !== 5'b00001 || remaining_s !== 3'd0) begin
      fails++; $display("FAIL clean_expiry got mode=%0d led=%b rem=%0d want mode=0 led=00001 rem=0",
                        mode_state, led, remaining_s);
    end
  endtask

  task automatic test_power_drop();
    menu_pulse();
    clean_btn = 1'b1; cyc(); clean_btn = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    power_on = 1'b0; cyc();
    checks++;
    if (mode_state !== 3'd5 || led !== 5'b00000 || remaining_s !== 3'd0 || menu_armed !== 1'b0) begin
      fails++; $display("FAIL power_drop got mode=%0d led=%b rem=%0d armed=%b want mode=5 led=0 rem=0 armed=0",
                        mode_state, led, remaining_s, menu_armed);
    end
    power_on = 1'b1; cyc();
    checks++;
    if (mode_state !== 3'd0 || led !== 5'b00001 || remaining_s !== 3'd0) begin
      fails++; $display("FAIL repower got mode=%0d led=%b rem=%0d want mode=0 led=00001 rem=0",
                        mode_state, led, remaining_s);
    end
  endtask

  task automatic test_reset_mid();
    menu_pulse();
    clean_btn = 1'b1; cyc(); clean_btn = 1'b0;
    for (int i = 0; i < 13; i++) cyc();
    rst = 1'b1; cyc();
    checks++;
    if (mode_state !== 3'd5 || led !== '0 || remaining_s !== '0 || menu_armed !== 1'b0) begin
      fails++; $display("FAIL reset_mid got mode=%0d led=%b rem=%0d armed=%b want mode=5 led=0 rem=0 armed=0",
                        mode_state, led, remaining_s, menu_armed);
    end
    rst = 1'b0; cyc();
    checks++;
    if (mode_state !== 3'd0 || remaining_s !== 3'd0) begin
      fails++; $display("FAIL reset_mid_release got mode=%0d rem=%0d want mode=0 rem=0", mode_state, remaining_s);
    end
  endtask

  task automatic test_hurricane_reentry();
    hurricane_en = 1'b1;
    menu_pulse();
    level_btn = 3'b100; cyc(); level_btn = '0;
    for (int i = 0; i < HS * CLK; i++) cyc();
    checks++;
    if (mode_state !== 3'd2) begin
      fails++; $display("FAIL reentry_exit got mode=%0d want 2", mode_state);
    end
    level_btn = 3'b100; cyc(); level_btn = '0;
`ifdef HOOD_HURRICANE_LOCK_EN
    checks++;
    if (mode_state !== 3'd2) begin
      fails++; $display("FAIL lock_refuse got mode=%0d want 2", mode_state);
    end
    menu_pulse();
    menu_pulse();
    level_btn = 3'b100; cyc(); level_btn = '0;
`endif
    checks++;
    if (mode_state !== 3'd3 || remaining_s !== 3'd3) begin
      fails++; $display("FAIL reentry got mode=%0d rem=%0d want mode=3 rem=3", mode_state, remaining_s);
    end
    menu_pulse();
    menu_pulse();
    checks++;
    if ({mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
      fails++; $display("FAIL reentry_model got=%b want=%b", {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      power_on     = ($urandom_range(0, 79) != 0);
      menu_btn     = (i < 2000) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
      level_btn    = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
      clean_btn    = ($urandom_range(0, 7) == 0);
      hurricane_en = ($urandom_range(0, 59) != 0);
      cyc();
      checks++;
      if ({mode_state, led, menu_armed, remaining_s} !== exp_vec(m)) begin
        fails++; $display("FAIL random cyc=%0d got=%b want=%b", i,
                          {mode_state, led, menu_armed, remaining_s}, exp_vec(m));
      end
    end
    rst = 1'b0; power_on = 1'b1; menu_btn = 1'b0; level_btn = '0; clean_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; power_on = 1'b1; menu_btn = 1'b0; level_btn = '0;
    clean_btn = 1'b0; hurricane_en = 1'b1;
    test_reset();
    test_levels();
    test_hurricane();
    test_hurricane_gated();
    test_clean();
    test_power_drop();
    test_reset_mid();
    test_hurricane_reentry();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
